carpbol_birimi: RTL and testbench
=================================

CARPBOL_BIRIMI -- requirements
Module: carpbol_birimi

Interface
REQ-001 Parameter: VERI_BIT, 32, operand/result width; only 32 supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 basla  input  1  start request, sampled on rising clk.
REQ-005 islem  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 islec1  input  32  rs1 operand (multiplicand/dividend).
REQ-007 islec2  input  32  rs2 operand (multiplier/divisor).
REQ-008 mesgul  output  1  high while an operation is in progress.
REQ-009 hazir  output  1  one-cycle pulse: sonuc valid.
REQ-010 sonuc  output  32  result; held stable until the next accepted start.

Function
REQ-011 The unit SHALL be the iterative execute-stage helper consumed by the CPU's YURUTGERIYAZ stage; operands come from the register-read stage.
REQ-012 FSM states SHALL be BOSTA, HESAPLA, BITIR; encoding fixed in the shared package.
REQ-013 Start SHALL be accepted only when basla=1 and mesgul=0 at an edge; islem, islec1, islec2 latched at that edge; state goes to HESAPLA.
REQ-014 basla while mesgul=1 SHALL be ignored; latched operands SHALL not change.
REQ-015 HESAPLA SHALL last exactly 32 cycles (5-bit step counter, 0..31), one shift-add (multiply) or restoring-subtract (divide) step per cycle, then go to BITIR.
REQ-016 BITIR SHALL last one cycle with hazir=1 and sonuc valid, then return to BOSTA.
REQ-017 Latency: start accepted at edge k -> hazir high during cycle between edges k+33 and k+34.
REQ-018 mesgul SHALL be high in HESAPLA only; low in BOSTA and BITIR.
REQ-019 basla=1 during BITIR SHALL be accepted (back-to-back); sonuc updates only at that op's BITIR.
REQ-020 Multiply SHALL form the 64-bit product on magnitudes with sign fix-up: MUL low 32 bits; MULH signed x signed high; MULHSU signed x unsigned high; MULHU unsigned high.
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign = dividend sign.
REQ-022 Divide by zero: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> islec1.
REQ-023 Signed overflow (islec1=32'h8000_0000, islec2=32'hFFFF_FFFF): DIV -> 32'h8000_0000; REM -> 0.
REQ-024 All arithmetic SHALL be modulo 2^32 on outputs; no exceptions or flags raised.

Reset
REQ-025 rst=1 at an edge SHALL force state BOSTA, counter 0, mesgul=0, hazir=0, sonuc=32'h0, latched operands 0.
REQ-026 rst SHALL take priority over basla and SHALL abort an in-flight operation with no hazir pulse.

Configuration
REQ-027 Macro CARPBOL_KISAYOL_EN defined: divide-by-zero and signed-overflow cases SHALL skip HESAPLA, going BOSTA -> BITIR directly (hazir between edges k+1 and k+2, mesgul never high).
REQ-028 Macro undefined: those cases SHALL run the full 32 steps; results identical to REQ-022/023, latency per REQ-017.

Structure
REQ-029 Shared package islemci_pkg SHALL hold the funct3 codes, FSM state encodings, VERI_BIT and step count 32.
REQ-030 One sub-module isaret_duzeltici SHALL be used: combinational operand absolute value and result negation per islem.

Verification
REQ-031 MUL 7 x 6, start at edge k -> hazir only in cycle k+33..k+34, sonuc=32'd42, mesgul high exactly 32 cycles.
REQ-032 MULH 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 0; MULHU same operands -> 32'hFFFF_FFFE; MULHSU 32'hFFFF_FFFF x 2 -> 32'hFFFF_FFFF.
REQ-033 DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIV 5/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5; DIV 32'h8000_0000/-1 -> 32'h8000_0000, REM -> 0; latency 34 without, 2 with CARPBOL_KISAYOL_EN.
REQ-035 basla pulsed at step 10 of a MUL -> ignored, first result unchanged; basla in BITIR cycle -> second op accepted, hazir 34 cycles later.
REQ-036 rst asserted at step 20 of a DIVU -> next cycle mesgul=0, sonuc=0, no hazir; a fresh op afterwards completes correctly.

Source files
------------

// File: rtl/islemci_pkg.sv
// islemci_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the RV32M funct3 codes, the FSM state encoding, the data width
// and the number of iteration steps.
package islemci_pkg;

    localparam int unsigned VERI_BIT    = 32;
    localparam int unsigned ADIM_SAYISI = 32;

    typedef enum logic [2:0] {
        ISL_MUL    = 3'd0,
        ISL_MULH   = 3'd1,
        ISL_MULHSU = 3'd2,
        ISL_MULHU  = 3'd3,
        ISL_DIV    = 3'd4,
        ISL_DIVU   = 3'd5,
        ISL_REM    = 3'd6,
        ISL_REMU   = 3'd7
    } islem_t;

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        BITIR   = 2'd2
    } durum_t;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic bolme_mi(input islem_t i);
        return i[2];
    endfunction

endpackage

// File: rtl/carpbol_birimi_isaret_duzeltici.sv
// isaret_duzeltici: combinational sign handling around the unsigned core.
//   islem   : operation (funct3)
//   islec1  : rs1 operand as latched
//   islec2  : rs2 operand as latched
//   ham     : unsigned core result; product for multiply,
//             {remainder, quotient} for divide
//   mutlak1 : |islec1| when rs1 is treated as signed, else islec1
//   mutlak2 : |islec2| when rs2 is treated as signed, else islec2
//   sonuc   : signed-corrected 32-bit result selected by islem
module isaret_duzeltici
    import islemci_pkg::*;
(
    input  islem_t                  islem,
    input  logic [VERI_BIT-1:0]     islec1,
    input  logic [VERI_BIT-1:0]     islec2,
    input  logic [2*VERI_BIT-1:0]   ham,
    output logic [VERI_BIT-1:0]     mutlak1,
    output logic [VERI_BIT-1:0]     mutlak2,
    output logic [VERI_BIT-1:0]     sonuc
);

    logic                  isaretli1;
    logic                  isaretli2;
    logic                  eksi1;
    logic                  eksi2;
    logic [2*VERI_BIT-1:0] carpim;
    logic [VERI_BIT-1:0]   bolum;
    logic [VERI_BIT-1:0]   kalan;

    always_comb begin
        isaretli1 = 1'b0;
        isaretli2 = 1'b0;
        unique case (islem)
            ISL_MULH, ISL_DIV, ISL_REM: begin
                isaretli1 = 1'b1;
                isaretli2 = 1'b1;
            end
            ISL_MULHSU: isaretli1 = 1'b1;
            default: ;
        endcase
    end

    assign eksi1   = isaretli1 & islec1[VERI_BIT-1];
    assign eksi2   = isaretli2 & islec2[VERI_BIT-1];
    assign mutlak1 = eksi1 ? -islec1 : islec1;
    assign mutlak2 = eksi2 ? -islec2 : islec2;

    // Quotient sign follows both operands; remainder sign follows the dividend.
    assign carpim = (eksi1 ^ eksi2) ? -ham : ham;
    assign bolum  = (eksi1 ^ eksi2) ? -ham[VERI_BIT-1:0] : ham[VERI_BIT-1:0];
    assign kalan  = eksi1 ? -ham[2*VERI_BIT-1:VERI_BIT] : ham[2*VERI_BIT-1:VERI_BIT];

    always_comb begin
        sonuc = carpim[VERI_BIT-1:0];
        unique case (islem)
            ISL_MUL:                        sonuc = carpim[VERI_BIT-1:0];
            ISL_MULH, ISL_MULHSU, ISL_MULHU: sonuc = carpim[2*VERI_BIT-1:VERI_BIT];
            ISL_DIV, ISL_DIVU:              sonuc = bolum;
            ISL_REM, ISL_REMU:              sonuc = kalan;
            default: ;
        endcase
    end

endmodule

// File: rtl/carpbol_birimi.sv
// carpbol_birimi: iterative RV32M multiply/divide unit for the execute stage.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, aborts any operation
//   basla  : start request; accepted when idle or in the finishing cycle
//   islem  : RV32M funct3 (MUL..REMU)
//   islec1 : rs1 operand (multiplicand / dividend)
//   islec2 : rs2 operand (multiplier / divisor)
//   mesgul : high during the 32 iteration cycles
//   hazir  : one-cycle pulse, sonuc valid
//   sonuc  : result, held until the next operation finishes
// Build option: CARPBOL_KISAYOL_EN lets divide-by-zero and signed overflow
// go straight to the finishing state without iterating.
module carpbol_birimi #(
    parameter int unsigned VERI_BIT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                basla,
    input  logic [2:0]          islem,
    input  logic [VERI_BIT-1:0] islec1,
    input  logic [VERI_BIT-1:0] islec2,
    output logic                mesgul,
    output logic                hazir,
    output logic [VERI_BIT-1:0] sonuc
);

    import islemci_pkg::*;

    localparam logic [4:0] SON_ADIM = 5'(ADIM_SAYISI - 1);

`ifdef CARPBOL_KISAYOL_EN
    localparam logic KISAYOL = 1'b1;
`else
    localparam logic KISAYOL = 1'b0;
`endif

    durum_t                durum;
    durum_t                durum_n;
    logic                  hazirla;
    logic                  kabul;
    logic [4:0]            sayac;
    islem_t                islem_r;
    logic [VERI_BIT-1:0]   islec1_r;
    logic [VERI_BIT-1:0]   islec2_r;
    logic [VERI_BIT-1:0]   hi_r;
    logic [VERI_BIT-1:0]   lo_r;
    logic [VERI_BIT-1:0]   bolen_r;
    logic [VERI_BIT-1:0]   sonuc_r;

    logic [VERI_BIT-1:0]   hi_n;
    logic [VERI_BIT-1:0]   lo_n;
    logic [VERI_BIT:0]     toplam;
    logic [VERI_BIT:0]     kaydir;
    logic [VERI_BIT-1:0]   fark;
    logic                  sigar;
    logic [VERI_BIT-1:0]   mutlak1;
    logic [VERI_BIT-1:0]   mutlak2;
    logic [VERI_BIT-1:0]   duz_sonuc;

    logic                  sifir_bolen;
    logic                  tasma;
    logic                  ozel;
    logic [VERI_BIT-1:0]   ozel_sonuc;

    isaret_duzeltici u_isaret (
        .islem   (islem_r),
        .islec1  (islec1_r),
        .islec2  (islec2_r),
        .ham     ({hi_n, lo_n}),
        .mutlak1 (mutlak1),
        .mutlak2 (mutlak2),
        .sonuc   (duz_sonuc)
    );

    // Divide-by-zero and signed-overflow results are fixed values.
    assign sifir_bolen = bolme_mi(islem_r) && (islec2_r == '0);
    assign tasma       = ((islem_r == ISL_DIV) || (islem_r == ISL_REM)) &&
                         (islec1_r == {1'b1, {(VERI_BIT-1){1'b0}}}) &&
                         (islec2_r == '1);
    assign ozel        = sifir_bolen | tasma;

    always_comb begin
        ozel_sonuc = '0;
        if (sifir_bolen)
            ozel_sonuc = ((islem_r == ISL_DIV) || (islem_r == ISL_DIVU)) ? '1 : islec1_r;
        else if (tasma)
            ozel_sonuc = (islem_r == ISL_DIV) ? {1'b1, {(VERI_BIT-1){1'b0}}} : '0;
    end

    // One iteration step. Multiply: shift-add with {hi,lo} as product and
    // lo holding the remaining multiplier bits. Divide: restoring, hi is the
    // partial remainder and lo shifts the dividend out / quotient bits in.
    always_comb begin
        toplam = {1'b0, hi_r} + (lo_r[0] ? {1'b0, bolen_r} : '0);
        kaydir = {hi_r, lo_r[VERI_BIT-1]};
        fark   = kaydir[VERI_BIT-1:0] - bolen_r;
        sigar  = (kaydir >= {1'b0, bolen_r});
        if (bolme_mi(islem_r)) begin
            hi_n = sigar ? fark : kaydir[VERI_BIT-1:0];
            lo_n = {lo_r[VERI_BIT-2:0], sigar};
        end else begin
            hi_n = toplam[VERI_BIT:1];
            lo_n = {toplam[0], lo_r[VERI_BIT-1:1]};
        end
    end

    // After acceptance there is one setup cycle in BOSTA (hazirla=1) that
    // loads operand magnitudes into the datapath; a start request arriving
    // in that cycle is ignored because an operation is already in flight.
    assign kabul = basla && (durum != HESAPLA) && !hazirla;

    always_comb begin
        durum_n = durum;
        mesgul  = 1'b0;
        hazir   = 1'b0;
        unique case (durum)
            BOSTA: begin
                if (hazirla)
                    durum_n = (KISAYOL && ozel) ? BITIR : HESAPLA;
            end
            HESAPLA: begin
                mesgul = 1'b1;
                if (sayac == SON_ADIM)
                    durum_n = BITIR;
            end
            BITIR: begin
                hazir   = 1'b1;
                durum_n = BOSTA;
            end
            default: durum_n = BOSTA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum    <= BOSTA;
            hazirla  <= 1'b0;
            sayac    <= '0;
            islem_r  <= ISL_MUL;
            islec1_r <= '0;
            islec2_r <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            bolen_r  <= '0;
            sonuc_r  <= '0;
        end else begin
            durum   <= durum_n;
            hazirla <= kabul;
            if (kabul) begin
                islem_r  <= islem_t'(islem);
                islec1_r <= islec1;
                islec2_r <= islec2;
            end
            if (hazirla) begin
                hi_r    <= '0;
                lo_r    <= mutlak1;
                bolen_r <= mutlak2;
                sayac   <= '0;
            end else if (durum == HESAPLA) begin
                hi_r  <= hi_n;
                lo_r  <= lo_n;
                sayac <= sayac + 5'd1;
            end
            if (durum_n == BITIR)
                sonuc_r <= ozel ? ozel_sonuc : duz_sonuc;
        end
    end

    assign sonuc = sonuc_r;

endmodule

// File: tb/tb_carpbol_birimi.sv
module tb_carpbol_birimi;
    import islemci_pkg::*;

`ifdef CARPBOL_KISAYOL_EN
    localparam int OZEL_GECIKME = 1;
`else
    localparam int OZEL_GECIKME = 33;
`endif
    localparam int NORMAL_GECIKME = 33;

    logic        clk;
    logic        rst;
    logic        basla;
    logic [2:0]  islem;
    logic [31:0] islec1;
    logic [31:0] islec2;
    logic        mesgul;
    logic        hazir;
    logic [31:0] sonuc;

    carpbol_birimi #(.VERI_BIT(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .basla  (basla),
        .islem  (islem),
        .islec1 (islec1),
        .islec2 (islec2),
        .mesgul (mesgul),
        .hazir  (hazir),
        .sonuc  (sonuc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       ad;
        logic [31:0] deger;
        int          cyc;
    } beklenti_t;

    beklenti_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            failures++;
            $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
        end
    endtask

    // Monitor: every hazir pulse must match the oldest expected result,
    // both in value and in the cycle it appears.
    beklenti_t b;
    always @(negedge clk) begin
        if (hazir === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_hazir: got hazir=1 sonuc=%h at cyc %0d expected no pulse", sonuc, cyc);
            end else begin
                b = sb.pop_front();
                kontrol({b.ad, "_sonuc"}, sonuc, b.deger);
                kontrol({b.ad, "_cyc"}, 32'(cyc), 32'(b.cyc));
            end
        end
    end

    // Called at a negedge; basla is sampled at the following edge.
    task automatic baslat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c,
                          input logic [31:0] beklenen, input bit kisa, input bit kaydet, input string ad);
        beklenti_t e;
        basla  = 1'b1;
        islem  = op;
        islec1 = a;
        islec2 = c;
        if (kaydet) begin
            e.ad    = ad;
            e.deger = beklenen;
            e.cyc   = cyc + 1 + (kisa ? OZEL_GECIKME : NORMAL_GECIKME);
            sb.push_back(e);
        end
        @(negedge clk);
        basla = 1'b0;
    endtask

    task automatic bitmesini_bekle(input string ad);
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout: got %0d pending results expected 0", ad, sb.size());
        sb.delete();
    endtask

    task automatic hazir_bekle(input string ad);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (hazir === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_no_hazir: got hazir=0 expected 1 within 80 cycles", ad);
    endtask

    task automatic tek(input logic [2:0] op, input logic [31:0] a, input logic [31:0] c,
                       input logic [31:0] beklenen, input bit kisa, input string ad);
        baslat(op, a, c, beklenen, kisa, 1'b1, ad);
        bitmesini_bekle(ad);
    endtask

    int mesgul_sayisi;

    initial begin
        rst    = 1'b1;
        basla  = 1'b0;
        islem  = 3'd0;
        islec1 = '0;
        islec2 = '0;
        repeat (3) @(negedge clk);
        kontrol("reset_mesgul", {31'b0, mesgul}, 32'd0);
        kontrol("reset_hazir",  {31'b0, hazir},  32'd0);
        kontrol("reset_sonuc",  sonuc,           32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7 x 6 with busy-length measurement
        baslat(ISL_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 1'b1, "mul_7x6");
        mesgul_sayisi = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (mesgul === 1'b1) mesgul_sayisi++;
            if (hazir === 1'b1) break;
        end
        kontrol("mul_mesgul_cycles", 32'(mesgul_sayisi), 32'd32);
        bitmesini_bekle("mul_7x6");

        // Multiply variants
        tek(ISL_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh_m1_m1");
        tek(ISL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        tek(ISL_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, "mulhsu_m1_2");
        tek(ISL_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 1'b0, "mul_m3_5");
        tek(ISL_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_min");

        // Divide variants
        tek(ISL_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        tek(ISL_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
        tek(ISL_DIVU, 32'd100,       32'd7, 32'd14,        1'b0, "divu_100_7");
        tek(ISL_REMU, 32'd100,       32'd7, 32'd2,         1'b0, "remu_100_7");

        // Divide by zero and signed overflow
        tek(ISL_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "div_5_0");
        tek(ISL_REM,  32'd5,         32'd0,         32'd5,         1'b1, "rem_5_0");
        tek(ISL_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "divu_5_0");
        tek(ISL_REMU, 32'd5,         32'd0,         32'd5,         1'b1, "remu_5_0");
        tek(ISL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        tek(ISL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf");

        // Start during busy is ignored; start during the finishing cycle is taken
        baslat(ISL_MUL, 32'd123, 32'd1000, 32'd123000, 1'b0, 1'b1, "mul_ignore");
        repeat (10) @(negedge clk);
        basla  = 1'b1;
        islem  = ISL_DIV;
        islec1 = 32'd99;
        islec2 = 32'd0;
        @(negedge clk);
        basla = 1'b0;
        hazir_bekle("mul_ignore");
        baslat(ISL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, "b2b_mulhu");
        bitmesini_bekle("b2b_mulhu");

        // Reset at step 20 of a DIVU aborts it without a result
        baslat(ISL_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, "abort");
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        kontrol("abort_mesgul", {31'b0, mesgul}, 32'd0);
        kontrol("abort_hazir",  {31'b0, hazir},  32'd0);
        kontrol("abort_sonuc",  sonuc,           32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        tek(ISL_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, "after_abort_divu");
        tek(ISL_REMU, 32'd1000, 32'd3, 32'd1,   1'b0, "after_abort_remu");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
